// File: rtl/stream_packer_pkg.sv
// Shared constants and state encoding for the sample packer and the averaging stage.
// Both blocks import this package so they agree on frame geometry.
package stream_packer_pkg;

   localparam int SAMPLE_W    = 8;
   localparam int NUM_SAMPLES = 8;
   localparam int FRAME_W     = SAMPLE_W * NUM_SAMPLES;

   // A single-sample frame still needs a one-bit counter to stay legal.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int CNT_W = cnt_width(NUM_SAMPLES);

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } fill_state_e;

endpackage

// File: rtl/stream_packer.sv
// Packs NUM_SAMPLES narrow samples MSB-first into one frame behind a valid/ready
// handshake, with one held frame in the assembly buffer and one in the output register.
module stream_packer #(
   parameter int  SAMPLE_W    = stream_packer_pkg::SAMPLE_W,
   parameter int  NUM_SAMPLES = stream_packer_pkg::NUM_SAMPLES,
   localparam int FRAME_W     = SAMPLE_W * NUM_SAMPLES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic [FRAME_W-1:0]  data_stream,
   output logic                frame_valid,
   input  logic                frame_ready,
   output logic [15:0]         frame_count
);

   import stream_packer_pkg::*;

   localparam int              CW   = cnt_width(NUM_SAMPLES);
   localparam logic [CW-1:0]   LAST = CW'(NUM_SAMPLES - 1);

   fill_state_e         state_q;
   logic [CW-1:0]       cnt_q;
   logic [FRAME_W-1:0]  asm_q;
   logic [FRAME_W-1:0]  out_q;
   logic                fv_q;
   logic [15:0]         fcount_q;

   logic [FRAME_W-1:0]  word_d;
   logic                accept;
   logic                slot_free;
   logic                handshake;

   // Ready depends only on registered state and rst, never on frame_ready.
   assign sample_ready = (state_q == FILL) && !rst;
   assign accept       = sample_valid && sample_ready;
   assign handshake    = fv_q && frame_ready;
   assign slot_free    = !fv_q || frame_ready;
   assign word_d       = (asm_q << SAMPLE_W) | FRAME_W'(sample_in);

   assign data_stream  = out_q;
   assign frame_valid  = fv_q;
   assign frame_count  = fcount_q;

   // NOTE: every state register, including the wide buffers, is cleared on reset so a
   // partial or held frame can never leak into the first frame after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FILL;
         cnt_q    <= '0;
         asm_q    <= '0;
         out_q    <= '0;
         fv_q     <= 1'b0;
         fcount_q <= '0;
      end else begin
         if (handshake) begin
            fcount_q <= fcount_q + 16'd1;
            fv_q     <= 1'b0;
         end

         unique case (state_q)
            FILL: begin
               if (accept) begin
                  if (cnt_q == LAST) begin
                     cnt_q <= '0;
                     if (slot_free) begin
                        out_q <= word_d;
                        fv_q  <= 1'b1;
                     end else begin
                        asm_q   <= word_d;
                        state_q <= FULL;
                     end
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                     asm_q <= word_d;
                  end
               end
            end
            FULL: begin
               if (slot_free) begin
                  out_q   <= asm_q;
                  fv_q    <= 1'b1;
                  state_q <= FILL;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_stream_packer.sv
// Scoreboard bench for stream_packer: the driver builds expected frames from accepted
// samples, the monitor compares them at every frame handshake.
module tb_stream_packer;

   localparam int SW = 8;
   localparam int NS = 8;
   localparam int FW = SW * NS;

   logic          clk = 1'b0;
   logic          rst;
   logic [SW-1:0] sample_in;
   logic          sample_valid;
   logic          sample_ready;
   logic [FW-1:0] data_stream;
   logic          frame_valid;
   logic          frame_ready;
   logic [15:0]   frame_count;

   // Second instance with one sample per frame: one handshake per cycle for the wrap test.
   logic          w_rst;
   logic [SW-1:0] w_sample;
   logic          w_valid;
   logic          w_sready;
   logic [SW-1:0] w_data;
   logic          w_fv;
   logic          w_fr;
   logic [15:0]   w_count;

   int n_checks = 0;
   int n_errors = 0;

   logic [FW-1:0] sb_q[$];
   logic [FW-1:0] model_word;
   int            model_n;
   logic [15:0]   exp_count;
   logic          armed = 1'b0;
   logic          prev_hold = 1'b0;
   logic [FW-1:0] prev_data;
   logic          hs;

   always #5 clk = ~clk;

   stream_packer #(.SAMPLE_W(SW), .NUM_SAMPLES(NS)) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .data_stream  (data_stream),
      .frame_valid  (frame_valid),
      .frame_ready  (frame_ready),
      .frame_count  (frame_count)
   );

   stream_packer #(.SAMPLE_W(SW), .NUM_SAMPLES(1)) dut_wrap (
      .clk          (clk),
      .rst          (w_rst),
      .sample_in    (w_sample),
      .sample_valid (w_valid),
      .sample_ready (w_sready),
      .data_stream  (w_data),
      .frame_valid  (w_fv),
      .frame_ready  (w_fr),
      .frame_count  (w_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Drive one sample and wait (bounded) until it is accepted; returns at posedge+1.
   task automatic send(input logic [SW-1:0] v);
      logic accepted;
      accepted     = 1'b0;
      sample_in    = v;
      sample_valid = 1'b1;
      for (int c = 0; c < 50 && !accepted; c++) begin
         @(negedge clk);
         accepted = sample_ready;
         @(posedge clk);
         #1;
      end
      check("send_accept", accepted, 1'b1);
      if (accepted) begin
         model_word = (model_word << SW) | FW'(v);
         model_n++;
         if (model_n == NS) begin
            sb_q.push_back(model_word);
            model_n    = 0;
            model_word = '0;
         end
      end
   endtask

   task automatic idle(input int n);
      sample_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: decides at the falling edge what the next rising edge will do.
   always @(negedge clk) begin
      if (armed) begin
         if (prev_hold) begin
            check("hold_valid", frame_valid, 1'b1);
            check("hold_data", data_stream, prev_data);
         end
         check("frame_count", frame_count, exp_count);
         hs = frame_valid && frame_ready && !rst;
         if (rst) begin
            sb_q.delete();
            exp_count = '0;
         end else if (hs) begin
            check("sb_nonempty", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) check("frame_data", data_stream, sb_q.pop_front());
            exp_count = exp_count + 16'd1;
         end
         prev_hold = frame_valid && !frame_ready && !rst;
         prev_data = data_stream;
      end
   end

   initial begin
      int hs_done;
      rst          = 1'b1;
      sample_in    = '0;
      sample_valid = 1'b0;
      frame_ready  = 1'b0;
      w_rst        = 1'b1;
      w_sample     = 8'h5A;
      w_valid      = 1'b0;
      w_fr         = 1'b0;
      model_word   = '0;
      model_n      = 0;
      exp_count    = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_ready_low", sample_ready, 1'b0);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      armed = 1'b1;
      @(negedge clk);
      check("post_rst_ready", sample_ready, 1'b1);
      check("post_rst_valid", frame_valid, 1'b0);
      check("post_rst_data", data_stream, 64'h0);

      // Basic back-to-back frame
      @(posedge clk);
      #1;
      frame_ready = 1'b1;
      for (int i = 1; i <= 8; i++) send(SW'(i * 8'h11));
      sample_valid = 1'b0;
      @(negedge clk);
      check("basic_valid", frame_valid, 1'b1);
      check("basic_data", data_stream, 64'h1122334455667788);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("basic_one_cycle", frame_valid, 1'b0);
      check("basic_count", frame_count, 16'd1);
      idle(2);

      // Backpressure: two frames, the second held in the assembly buffer
      frame_ready = 1'b0;
      for (int i = 1; i <= 16; i++) send(SW'(i));
      sample_valid = 1'b0;
      @(negedge clk);
      check("bp_ready_low", sample_ready, 1'b0);
      check("bp_first_data", data_stream, 64'h0102030405060708);
      idle(3);
      @(negedge clk);
      check("bp_still_full", sample_ready, 1'b0);
      @(posedge clk);
      #1;
      frame_ready = 1'b1;
      @(negedge clk);
      check("bp_out_a", data_stream, 64'h0102030405060708);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_out_b", data_stream, 64'h090A0B0C0D0E0F10);
      check("bp_out_b_valid", frame_valid, 1'b1);
      check("bp_ready_back", sample_ready, 1'b1);
      idle(2);
      @(negedge clk);
      check("bp_drained", frame_valid, 1'b0);

      // Last sample accepted on the same edge as a frame handshake
      @(posedge clk);
      #1;
      frame_ready = 1'b0;
      for (int i = 1; i <= 8; i++) send(SW'(8'hC0 + i));
      for (int i = 1; i <= 7; i++) send(SW'(8'hD0 + i));
      frame_ready = 1'b1;
      send(8'hD8);
      sample_valid = 1'b0;
      @(negedge clk);
      check("simul_valid", frame_valid, 1'b1);
      check("simul_data", data_stream, 64'hD1D2D3D4D5D6D7D8);
      check("simul_ready", sample_ready, 1'b1);
      idle(3);

      // Gaps between samples
      for (int i = 1; i <= 8; i++) begin
         send(SW'(8'hA0 + i));
         idle(1);
      end
      @(negedge clk);
      check("gap_data", data_stream, 64'hA1A2A3A4A5A6A7A8);
      idle(3);
      @(negedge clk);
      check("gap_count", frame_count, 16'd6);

      // Reset with a held frame and a partial fill
      @(posedge clk);
      #1;
      frame_ready = 1'b0;
      for (int i = 1; i <= 8; i++) send(SW'(8'h30 + i));
      for (int i = 0; i < 3; i++) send(8'hFF);
      sample_valid = 1'b0;
      rst          = 1'b1;
      @(negedge clk);
      check("rst_mid_ready", sample_ready, 1'b0);
      @(posedge clk);
      #1;
      rst         = 1'b0;
      model_n     = 0;
      model_word  = '0;
      frame_ready = 1'b1;
      @(negedge clk);
      check("rst_mid_ready1", sample_ready, 1'b1);
      check("rst_mid_valid", frame_valid, 1'b0);
      check("rst_mid_data", data_stream, 64'h0);
      check("rst_mid_count", frame_count, 16'd0);
      @(posedge clk);
      #1;
      for (int i = 1; i <= 8; i++) send(SW'(i));
      sample_valid = 1'b0;
      @(negedge clk);
      check("rst_clean_data", data_stream, 64'h0102030405060708);
      idle(2);
      @(negedge clk);
      check("rst_clean_count", frame_count, 16'd1);
      check("sb_empty", sb_q.size(), 64'd0);

      // frame_count wrap on the one-sample-per-frame instance
      @(posedge clk);
      #1;
      w_rst   = 1'b0;
      w_valid = 1'b1;
      w_fr    = 1'b1;
      hs_done = 0;
      for (int c = 0; c < 70000 && hs_done < 65536; c++) begin
         @(negedge clk);
         if (hs_done == 65535) check("wrap_ffff", w_count, 16'hFFFF);
         if (w_fv && w_fr) hs_done++;
      end
      check("wrap_handshakes", hs_done, 64'd65536);
      @(negedge clk);
      check("wrap_zero", w_count, 16'h0000);
      check("wrap_data", w_data, 8'h5A);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
